// File: rtl/id_decode_unit.sv
// -----------------------------------------------------------------------------
// id_decode_unit
// Instruction-decode stage datapath of a 5-stage MIPS pipeline. It sits between
// the IF/ID and ID/EX pipeline registers.
//   - 32x32 architectural register file. It is written from WB on the rising
//     clock edge and read combinationally by the instruction in ID.
//   - Sign extension of the 16-bit immediate.
//   - Branch target computation: pcPlus4 + (imm << 2), modulo 2^32.
//   - Early equality flag (zero) for branch resolution in ID.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   When defined, a WB write to rs/rt (other than register 0) is forwarded to
//   the read outputs in the same cycle. The bypass is inhibited while rst=1.
//   When undefined, a same-cycle read returns the stored (old) value.
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous active-high reset (clears all registers)
//   RegWrite        in   1   register-file write enable from WB
//   instruction     in  32   IF/ID instruction (rs=[25:21], rt=[20:16], imm=[15:0])
//   write_reg       in   5   WB destination register index
//   write_data_reg  in  32   WB write data
//   pcPlus4         in  32   PC+4 of the instruction in ID
//   inst_extended   out 32   sign-extended immediate
//   read_data1_reg  out 32   register[rs]
//   read_data2_reg  out 32   register[rt]
//   branch_adder_id out 32   branch target address
//   zero            out  1   1 when read_data1_reg == read_data2_reg
// -----------------------------------------------------------------------------
module id_decode_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [31:0]       instruction,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data_reg,
  input  logic [31:0]       pcPlus4,
  output logic [31:0]       inst_extended,
  output logic [DATA_W-1:0] read_data1_reg,
  output logic [DATA_W-1:0] read_data2_reg,
  output logic [31:0]       branch_adder_id,
  output logic              zero
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_stored1;
  logic [DATA_W-1:0] w_stored2;
  logic [31:0]       w_imm_shifted;
  logic              w_unused_opcode;

  assign w_rs = instruction[25:21];
  assign w_rt = instruction[20:16];

  // The opcode and funct fields are decoded elsewhere.
  assign w_unused_opcode = ^instruction[31:26];

  // Register file storage: reset clears everything, and writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (RegWrite && (write_reg != 5'd0)) begin
      r_regs[write_reg] <= write_data_reg;
    end
  end

  // Stored read values, with register 0 forced to zero regardless of array contents.
  always_comb begin
    w_stored1 = '0;
    w_stored2 = '0;
    if (w_rs != 5'd0) begin
      w_stored1 = r_regs[w_rs];
    end else begin
      w_stored1 = '0;
    end
    if (w_rt != 5'd0) begin
      w_stored2 = r_regs[w_rt];
    end else begin
      w_stored2 = '0;
    end
  end

`ifdef ID_WB_BYPASS_EN
  // Write-through forwarding of the WB value; suppressed during reset so outputs follow stored state.
  always_comb begin
    read_data1_reg = w_stored1;
    read_data2_reg = w_stored2;
    if (!rst && RegWrite && (write_reg != 5'd0) && (write_reg == w_rs)) begin
      read_data1_reg = write_data_reg;
    end else begin
      read_data1_reg = w_stored1;
    end
    if (!rst && RegWrite && (write_reg != 5'd0) && (write_reg == w_rt)) begin
      read_data2_reg = write_data_reg;
    end else begin
      read_data2_reg = w_stored2;
    end
  end
`else
  // Without forwarding, a same-cycle read sees the value held before the write edge.
  always_comb begin
    read_data1_reg = w_stored1;
    read_data2_reg = w_stored2;
  end
`endif

  // Immediate sign extension and branch target; the top two bits shifted out are dropped.
  always_comb begin
    inst_extended   = {{16{instruction[15]}}, instruction[15:0]};
    w_imm_shifted   = {inst_extended[29:0], 2'b00};
    branch_adder_id = pcPlus4 + w_imm_shifted;
  end

  // Early branch comparison uses the same (possibly forwarded) values as the read ports.
  always_comb begin
    zero = (read_data1_reg == read_data2_reg);
  end

endmodule

// File: tb/tb_id_decode_unit.sv
module tb_id_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [31:0] instruction;
  logic [4:0]  write_reg;
  logic [31:0] write_data_reg;
  logic [31:0] pcPlus4;
  logic [31:0] inst_extended;
  logic [31:0] read_data1_reg;
  logic [31:0] read_data2_reg;
  logic [31:0] branch_adder_id;
  logic        zero;

  int n_checks   = 0;
  int n_failures = 0;

  // Reference register file as a plain array; valid once a reset edge has been seen.
  logic [31:0] model_regs [32];
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  id_decode_unit dut (
    .clk             (clk),
    .rst             (rst),
    .RegWrite        (RegWrite),
    .instruction     (instruction),
    .write_reg       (write_reg),
    .write_data_reg  (write_data_reg),
    .pcPlus4         (pcPlus4),
    .inst_extended   (inst_extended),
    .read_data1_reg  (read_data1_reg),
    .read_data2_reg  (read_data2_reg),
    .branch_adder_id (branch_adder_id),
    .zero            (zero)
  );

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_failures++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'd0 : model_regs[idx];
`ifdef ID_WB_BYPASS_EN
    if (!rst && RegWrite && write_reg != 5'd0 && write_reg == idx) v = write_data_reg;
`endif
    return v;
  endfunction

  function automatic longint ref_imm_value(input logic [15:0] imm);
    longint s;
    s = longint'(imm);
    if (s >= 64'sd32768) s = s - 64'sd65536;
    return s;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    longint t;
    t = longint'(pc) + ref_imm_value(imm) * 64'sd4;
    return t[31:0];
  endfunction

  function automatic logic [31:0] make_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic check_model();
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ext;
    e1  = ref_read(instruction[25:21]);
    e2  = ref_read(instruction[20:16]);
    ext = ref_imm_value(instruction[15:0]);
    check_value("rd1", read_data1_reg, e1);
    check_value("rd2", read_data2_reg, e2);
    check_value("zero", {31'd0, zero}, {31'd0, (e1 == e2)});
    check_value("ext", inst_extended, ext);
    check_value("target", branch_adder_id, ref_target(pcPlus4, instruction[15:0]));
  endtask

  // Drive a cycle's inputs and compare the combinational outputs at the falling edge.
  task automatic drive(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [31:0] instr, input logic [31:0] pc);
    rst            = r;
    RegWrite       = we;
    write_reg      = wr;
    write_data_reg = wd;
    instruction    = instr;
    pcPlus4        = pc;
    @(negedge clk);
    if (model_valid) check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_valid = 1'b1;
    end else if (RegWrite && write_reg != 5'd0) begin
      model_regs[write_reg] = write_data_reg;
    end
    #1;
  endtask

  initial begin
    logic [4:0] rs;
    logic [4:0] rt;

    // Reset, then read rs=5, rt=31.
    drive(1'b1, 1'b0, 5'd0, 32'd0, make_instr(5'd5, 5'd31, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd5, 5'd31, 16'd0), 32'd0);
    check_value("reset_rd1", read_data1_reg, 32'd0);
    check_value("reset_rd2", read_data2_reg, 32'd0);
    check_value("reset_zero", {31'd0, zero}, 32'd1);
    tick();

    // Write then read.
    drive(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd8, 5'd0, 16'd0), 32'd0);
    check_value("wr_rd1", read_data1_reg, 32'hDEADBEEF);
    check_value("wr_rd2", read_data2_reg, 32'd0);
    check_value("wr_zero", {31'd0, zero}, 32'd0);
    tick();

    // Register 0 is never written.
    drive(1'b0, 1'b1, 5'd0, 32'h12345678, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd0, 5'd0, 16'd0), 32'd0);
    check_value("r0_rd1", read_data1_reg, 32'd0);
    check_value("r0_rd2", read_data2_reg, 32'd0);
    tick();

    // RegWrite=0 leaves reg 9 alone.
    drive(1'b0, 1'b1, 5'd9, 32'h00000099, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd9, 32'h55555555, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd9, 5'd0, 16'd0), 32'd0);
    check_value("nowe_rd1", read_data1_reg, 32'h00000099);
    tick();

    // Sign extension and branch targets.
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd0, 5'd0, 16'h8000), 32'h00400010);
    check_value("ext_neg", inst_extended, 32'hFFFF8000);
    check_value("tgt_neg", branch_adder_id, 32'h003E0010);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd0, 5'd0, 16'h0004), 32'h00400010);
    check_value("tgt_pos", branch_adder_id, 32'h00400020);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd0, 5'd0, 16'hFFFF), 32'h00000000);
    check_value("tgt_wrap", branch_adder_id, 32'hFFFFFFFC);
    tick();

    // Read during write of reg 3.
    drive(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, make_instr(5'd3, 5'd0, 16'd0), 32'd0);
`ifdef ID_WB_BYPASS_EN
    check_value("rdw_same", read_data1_reg, 32'hA5A5A5A5);
`else
    check_value("rdw_same", read_data1_reg, 32'd0);
`endif
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd3, 5'd0, 16'd0), 32'd0);
    check_value("rdw_after", read_data1_reg, 32'hA5A5A5A5);
    tick();

    // Comparator.
    drive(1'b0, 1'b1, 5'd4, 32'd7, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b1, 5'd5, 32'd7, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd4, 5'd5, 16'd0), 32'd0);
    check_value("cmp_eq", {31'd0, zero}, 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'd5, 32'd8, make_instr(5'd1, 5'd2, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd4, 5'd5, 16'd0), 32'd0);
    check_value("cmp_ne", {31'd0, zero}, 32'd0);
    tick();

    // Reset wins over a simultaneous write.
    drive(1'b1, 1'b1, 5'd10, 32'hFFFFFFFF, make_instr(5'd10, 5'd4, 16'd0), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, make_instr(5'd10, 5'd4, 16'd0), 32'd0);
    check_value("rstpri_rd1", read_data1_reg, 32'd0);
    check_value("rstpri_rd2", read_data2_reg, 32'd0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
      end else begin
        rs = 5'($urandom);
        rt = 5'($urandom);
      end
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) == 0) ? rs : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'd7 : 32'($urandom),
            {6'($urandom), rs, rt, 16'($urandom)},
            32'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/id_decode_unit.md
Name: id_decode_unit

Overview:
Instruction-decode stage datapath of the 5-stage MIPS pipeline, sitting between the IF/ID and ID/EX pipeline registers.
- Holds the 32x32 architectural register file, written from WB and read combinationally by the instruction in ID.
- Sign-extends the 16-bit immediate.
- Computes the branch target pcPlus4 + (imm << 2).
- Produces an early equality flag (zero) for branch resolution in ID.

Parameters:
- DATA_W, 32, datapath/register width; must be 32 for MIPS semantics.
- NUM_REGS, 32, register count; address width is fixed at 5 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  1  register-file write enable from WB control.
- instruction  in  32  IF/ID instruction: rs=[25:21], rt=[20:16], imm=[15:0].
- write_reg  in  5  WB destination register index.
- write_data_reg  in  32  WB write data.
- pcPlus4  in  32  PC+4 of the instruction in ID.
- inst_extended  out  32  sign-extended immediate.
- read_data1_reg  out  32  register[rs].
- read_data2_reg  out  32  register[rt].
- branch_adder_id  out  32  branch target address.
- zero  out  1  1 when read_data1_reg == read_data2_reg.

Behaviour:
Register file
- 32 registers of 32 bits.
- On a rising clk edge with rst=1: all registers are cleared to 0. Reset has priority over any write in the same cycle.
- On a rising clk edge with rst=0 and RegWrite=1: register[write_reg] <= write_data_reg.
- Register 0 is hardwired to 0. Writes to it are ignored, and reads of it always return 0.
- Reads are combinational, from instruction[25:21] and instruction[20:16].
- No write occurs when RegWrite=0, whatever write_reg and write_data_reg are.
- Read-during-write with macro absent: a same-cycle read of the register being written returns the old value; the new value is visible after the clock edge.
- rst is ignored between clock edges: outputs reflect the cleared state only after the reset edge.

Sign extension
- inst_extended = {16{instruction[15]}, instruction[15:0]}; purely combinational.

Branch adder
- branch_adder_id = pcPlus4 + (inst_extended << 2), modulo 2^32.
- Carry-out is discarded and wrap-around is silent.
- The shifted-out top 2 bits of inst_extended are discarded.

Comparator
- zero = (read_data1_reg == read_data2_reg), full 32-bit compare, combinational.
- With the bypass feature enabled, zero uses the bypassed values.

Timing and outputs
- All outputs except register state are combinational from inputs and current register contents; latency is 0 cycles. Register updates are visible 1 cycle after the write.
- No handshakes and no state machine.
- Outputs after reset: read data = 0; zero = 1; inst_extended and branch_adder_id follow the inputs.

Optional Feature:
Macro: ID_WB_BYPASS_EN
- Defined: internal write-through bypass. If RegWrite=1, write_reg != 0 and write_reg equals rs (or rt), the corresponding read output returns write_data_reg in the same cycle. zero uses the bypassed values.
- Undefined: no bypass; same-cycle reads return the stored (old) value.
- Reset still takes priority: while rst=1, the bypass is inhibited and outputs come from stored state.

Test Plan:
- Reset: rst=1 for one edge, then read rs=5, rt=31 -> read_data1_reg=0, read_data2_reg=0, zero=1.
- Write then read: RegWrite=1, write_reg=8, data=0xDEADBEEF, one edge; instruction rs=8, rt=0 -> read_data1_reg=0xDEADBEEF, read_data2_reg=0, zero=0.
- Register 0 and write disable:
  - Write 0x12345678 to reg 0 -> reads of reg 0 return 0.
  - RegWrite=0 with write_reg=9 -> reg 9 is unchanged.
- Sign extension and branch target:
  - imm=0x8000, pcPlus4=0x00400010 -> inst_extended=0xFFFF8000, branch_adder_id=0x003E0010.
  - imm=0x0004, pcPlus4=0x00400010 -> branch_adder_id=0x00400020.
  - imm=0xFFFF, pcPlus4=0x00000000 -> branch_adder_id=0xFFFFFFFC (wrap-around).
- Read-during-write: write reg 3 = 0xA5A5A5A5 while rs=3 in the same cycle.
  - Macro undefined -> old value before the edge, new value after.
  - Macro defined -> 0xA5A5A5A5 immediately.
- Comparator and reset-priority:
  - reg4 = reg5 = 7 -> zero=1; reg5 changed to 8 -> zero=0.
  - rst=1 together with RegWrite=1 -> register stays 0.
